// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin sharing of one fp16 multiplier among NUM_REQ
// requesters. Winning operands are registered into the multiplier and the
// requester ID rides a tag pipeline matched to the multiplier latency.
// Optional grant statistics are enabled by defining FP16_MUL_ARB_STATS_EN.
module fp16_mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [16*NUM_REQ-1:0]      req_a,
  input  logic [16*NUM_REQ-1:0]      req_b,
  output logic [15:0]                mul_a,
  output logic [15:0]                mul_b,
  input  logic [15:0]                mul_result,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [15:0]                rsp_result,
`ifdef FP16_MUL_ARB_STATS_EN
  input  logic                       stat_clr,
  output logic [CNT_W*NUM_REQ-1:0]   stat_grants,
`endif
  output logic                       busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned DEPTH = MUL_LATENCY + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_W < 1) begin : g_bad_cfg
    $error("fp16_mul_arbiter: unsupported parameter set");
  end

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    idx;
  logic [ID_W-1:0]    gnt_id;
  logic               found;
  logic               hs;

  logic [ID_W-1:0]    last_q, last_d;
  logic [15:0]        mul_a_q, mul_a_d;
  logic [15:0]        mul_b_q, mul_b_d;
  logic               tag_vld_q [DEPTH];
  logic               tag_vld_d [DEPTH];
  logic [ID_W-1:0]    tag_id_q  [DEPTH];
  logic [ID_W-1:0]    tag_id_d  [DEPTH];

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant  = '0;
    idx    = '0;
    gnt_id = '0;
    found  = 1'b0;
    hs     = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
    // Reset suppresses the grant so no handshake can complete during it.
    hs = found && !rst;
    if (hs) grant[gnt_id] = 1'b1;
  end

  // Next state: operand capture, pointer advance and tag shift.
  always_comb begin
    last_d  = last_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    if (hs) begin
      last_d  = gnt_id;
      mul_a_d = req_a[16*gnt_id +: 16];
      mul_b_d = req_b[16*gnt_id +: 16];
    end
    tag_vld_d[0] = hs;
    tag_id_d[0]  = gnt_id;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  // State registers; reset puts requester 0 at top priority and drops tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= ID_W'(NUM_REQ - 1);
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      tag_vld_q <= '{default: 1'b0};
      tag_id_q  <= '{default: '0};
    end else begin
      last_q    <= last_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  // Busy whenever any tag stage holds a live operation.
  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) busy = busy | tag_vld_q[k];
  end

  assign req_ready  = grant;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_valid  = tag_vld_q[DEPTH-1];
  assign rsp_id     = tag_id_q[DEPTH-1];
  assign rsp_result = mul_result;

`ifdef FP16_MUL_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];

  // Saturating per-requester grant counters; clear wins over increment.
  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr) begin
        cnt_d[i] = '0;
      end else if (hs && gnt_id == ID_W'(i) && cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      stat_grants[CNT_W*i +: CNT_W] = cnt_q[i];
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '{default: '0};
    else     cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb_fp16_mul_arbiter: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model
// (expected grant, expected multiplier operands, queue of pending products).
// Define FP16_MUL_ARB_STATS_EN to also exercise the grant counters (CNT_W=2).
module tb_fp16_mul_arbiter;

  localparam int NR = 4;
  localparam int ML = 1;
`ifdef FP16_MUL_ARB_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [16*NR-1:0] req_a, req_b;
  logic [15:0]   mul_a, mul_b, mul_result;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_result;
  logic          busy;
`ifdef FP16_MUL_ARB_STATS_EN
  logic          stat_clr;
  logic [CW*NR-1:0] stat_grants;
`endif

  fp16_mul_arbiter #(.NUM_REQ(NR), .MUL_LATENCY(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
`ifdef FP16_MUL_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_grants(stat_grants),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fp16 multiply, round-to-nearest-even; subnormals flush to zero.
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int e;
    int unsigned ma, mb, p, m, rem, half;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
    if (a[14:10] == 5'd31 || b[14:10] == 5'd31) return {s, 5'h1F, 10'd0};
    ma = 1024 + int'(a[9:0]);
    mb = 1024 + int'(b[9:0]);
    p  = ma * mb;
    e  = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p >= 2097152) begin
      m = p / 2048; rem = p % 2048; half = 1024; e = e + 1;
    end else begin
      m = p / 1024; rem = p % 1024; half = 512;
    end
    if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
    if (m == 2048) begin m = 1024; e = e + 1; end
    if (e >= 31) return {s, 5'h1F, 10'd0};
    if (e <= 0)  return {s, 15'd0};
    return {s, 5'(e), 10'(m % 1024)};
  endfunction

  // Behavioural multiplier with MUL_LATENCY = 1.
  always @(posedge clk) mul_result <= fp16_mul(mul_a, mul_b);

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          due;
  } pend_t;

  pend_t       pq[$];
  int          last;
  logic [15:0] exp_a, exp_b;
  int          cyc;
  int          n_vec;
  int          n_err;
  int          cnt [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    last  = NR - 1;
    exp_a = '0;
    exp_b = '0;
    pq.delete();
    for (int i = 0; i < NR; i++) cnt[i] = 0;
  endtask

  // One clock cycle: drive, check at negedge, advance model, pass the edge.
  task automatic cycle(input logic r, input logic [NR-1:0] v,
                       input logic [16*NR-1:0] a, input logic [16*NR-1:0] b);
    int g;
    logic [NR-1:0] exp_rdy;
    pend_t h;
    rst = r; req_valid = v; req_a = a; req_b = b;
    @(negedge clk);
    g = -1;
    if (!r) begin
      for (int k = 1; k <= NR; k++) begin
        if (g < 0 && v[(last + k) % NR]) g = (last + k) % NR;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("mul_a", 32'(mul_a), 32'(exp_a));
    chk("mul_b", 32'(mul_b), 32'(exp_b));
    chk("busy", 32'(busy), 32'(pq.size() != 0));
    if (pq.size() != 0 && pq[0].due == cyc) begin
      h = pq.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(h.id));
      chk("rsp_result", 32'(rsp_result), 32'(h.prod));
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 32'd0);
    end
`ifdef FP16_MUL_ARB_STATS_EN
    for (int i = 0; i < NR; i++) chk("stat_grants", 32'(stat_grants[CW*i +: CW]), 32'(cnt[i]));
`endif
    if (r) begin
      model_reset();
    end else begin
`ifdef FP16_MUL_ARB_STATS_EN
      if (stat_clr) begin
        for (int i = 0; i < NR; i++) cnt[i] = 0;
      end else if (g >= 0 && cnt[g] < (1 << CW) - 1) begin
        cnt[g]++;
      end
`endif
      if (g >= 0) begin
        last  = g;
        exp_a = a[16*g +: 16];
        exp_b = b[16*g +: 16];
        pq.push_back('{id: g, prod: fp16_mul(a[16*g +: 16], b[16*g +: 16]), due: cyc + ML + 1});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0);
  endtask

  function automatic logic [16*NR-1:0] rnd_ops();
    return {$urandom, $urandom};
  endfunction

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
`ifdef FP16_MUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Single issue from requester 0.
    cycle(1'b0, 4'b0001, {48'd0, 16'h553F}, {48'd0, 16'hD304});
    idle(4);

    // All requesters continuously valid from reset.
    cycle(1'b1, '0, '0, '0);
    for (int i = 0; i < 12; i++) begin
      logic [16*NR-1:0] a, b;
      a = rnd_ops(); b = rnd_ops();
      a[31:16] = 16'h49BA; b[31:16] = 16'h3CCB;
      cycle(1'b0, 4'b1111, a, b);
    end
    idle(3);

    // Pointer at 3, only requesters 2 and 3 valid.
    cycle(1'b1, '0, '0, '0);
    cycle(1'b0, 4'b1000, rnd_ops(), rnd_ops());
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'b1100, rnd_ops(), rnd_ops());
    idle(3);

    // Idle gaps between issues.
    cycle(1'b0, 4'b0001, rnd_ops(), rnd_ops());
    idle(3);
    cycle(1'b0, 4'b0010, rnd_ops(), rnd_ops());
    idle(4);

    // Reset in the cycle after a handshake.
    cycle(1'b0, 4'b0100, rnd_ops(), rnd_ops());
    cycle(1'b1, 4'b1111, rnd_ops(), rnd_ops());
    cycle(1'b0, 4'b1111, rnd_ops(), rnd_ops());
    idle(3);

`ifdef FP16_MUL_ARB_STATS_EN
    // Counter saturation and clear priority.
    cycle(1'b1, '0, '0, '0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0010, rnd_ops(), rnd_ops());
    idle(1);
    stat_clr = 1'b1;
    cycle(1'b0, '0, '0, '0);
    cycle(1'b0, 4'b0010, rnd_ops(), rnd_ops());
    stat_clr = 1'b0;
    idle(3);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic [NR-1:0] v;
      r = ($urandom_range(0, 49) == 0);
      v = NR'($urandom) & NR'($urandom | $urandom);
`ifdef FP16_MUL_ARB_STATS_EN
      stat_clr = ($urandom_range(0, 19) == 0);
`endif
      cycle(r, v, rnd_ops(), rnd_ops());
    end
`ifdef FP16_MUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp16_mul_arbiter.md
Name: fp16_mul_arbiter

Overview:
- Shares one fp16 multiplier among NUM_REQ requesters using round-robin arbitration.
- Each requester offers an operand pair on a valid/ready handshake. The block registers the winning operands into the multiplier and tracks the requester ID through the multiplier's fixed latency.
- It returns each product with the originating ID.
- Sits between the compute clients and the single multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 1, cycles from operands registered at the multiplier input to the product being valid on mul_result.
- CNT_W, 16, width of per-requester statistics counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has an operand pair.
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high.
- req_a  in  16*NUM_REQ  operand A, slice i = [16*i+15:16*i].
- req_b  in  16*NUM_REQ  operand B, same slicing.
- mul_a  out  16  registered operand A to the multiplier.
- mul_b  out  16  registered operand B to the multiplier.
- mul_result  in  16  multiplier product.
- rsp_valid  out  1  product valid this cycle.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that issued the product.
- rsp_result  out  16  product (equals mul_result while rsp_valid).
- busy  out  1  at least one operation in flight.

Behaviour:
- Reset (rst high at a clock edge):
  - mul_a = mul_b = 16'h0000, rsp_valid = 0, rsp_id = 0, busy = 0.
  - Round-robin pointer is set so requester 0 has top priority.
  - Tag pipeline is cleared. Operations in flight are dropped and no rsp_valid is produced for them.
  - req_ready = 0 while rst is high.
- Arbitration:
  - Combinational, one grant per cycle maximum.
  - Search order starts at (last_granted+1) mod NUM_REQ and wraps.
  - req_ready[i] is high only for the selected requester, and only when req_valid[i] is high.
  - The pointer updates only on a completed handshake.
  - No grant when no req_valid is set; the pointer holds.
- Issue:
  - Handshake in cycle t: mul_a/mul_b load the granted operands at the end of cycle t, so they are visible in cycle t+1.
  - A valid bit and the ID enter a MUL_LATENCY+1 deep tag shift register.
  - With no grant, mul_a/mul_b hold their previous value (no toggling) and a zero valid bit is shifted in.
- Response:
  - rsp_valid, rsp_id come from the tail of the tag pipeline.
  - rsp_result = mul_result combinationally.
  - Total latency is MUL_LATENCY+1 cycles from handshake to rsp_valid (2 cycles at default).
  - Fully pipelined: back-to-back grants give back-to-back responses in grant order.
  - No response backpressure; the consumer must accept every rsp_valid cycle.
- busy: OR of all tag-pipeline valid bits.
- Operands are treated as opaque 16-bit values. No fp interpretation and no special-case handling in this block.
- Simultaneous events:
  - Fairness: a requester holding req_valid is granted within NUM_REQ cycles.
  - A requester may deassert req_valid without handshake (no stickiness required).
- Reset asserted mid-operation: takes priority over any handshake in the same cycle; no grant is issued that cycle.

Optional Feature:
- Macro: FP16_MUL_ARB_STATS_EN.
- When defined, adds output stat_grants (CNT_W*NUM_REQ). Slice i counts completed handshakes of requester i and saturates at all-ones (no wrap).
- Adds input stat_clr (1): synchronous clear of all counters. stat_clr takes priority over an increment in the same cycle.
- Counters are cleared by rst.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Single issue, req0:
   - Stimulus: a=16'h553F, b=16'hD304, valid for one handshake in cycle 0.
   - Required: mul_a=16'h553F and mul_b=16'hD304 in cycle 1.
   - Model product 16'hEC9A. rsp_valid=1, rsp_id=0, rsp_result=16'hEC9A in cycle 2 only. busy high in cycles 1–2.
2. All four requesters valid continuously from reset:
   - Required grant order 0,1,2,3,0,...
   - rsp_id follows the same sequence with 2-cycle offset and rsp_valid high every cycle.
   - req1 issues 16'h49BA × 16'h3CCB and its response carries 16'h4ADD.
3. Only req2 and req3 valid, pointer at 3:
   - Required: next grant is req2, then req3 alternating. req0/req1 ready stays 0.
4. Idle gaps:
   - Stimulus: handshake, 3 idle cycles, handshake.
   - Required: mul_a/mul_b hold between issues; exactly two rsp_valid pulses, 4 cycles apart.
5. Reset mid-flight:
   - Stimulus: assert rst in the cycle after a handshake.
   - Required: no rsp_valid for that operation; busy=0, mul_a=mul_b=0 after reset; the next grant goes to req0 first.
6. FP16_MUL_ARB_STATS_EN with CNT_W=2:
   - Stimulus: 5 grants to req1.
   - Required: stat_grants slice 1 = 2'b11 (saturated). stat_clr pulse gives 0; a grant coincident with stat_clr still gives 0.
